dft_preproc: RTL

- Front-end of the any-point LTE DFT chain. Receives an N-point block (N = trans_len_i, an LTE DFT size) and resamples it by circular linear interpolation to the M = 2^ldn points the FFT core consumes.
- Postproc later corrects the interpolator's frequency response.
- Ping-pong buffered: one bank fills while the other streams to the FFT.
- When N == M, samples pass through unchanged (bypass).

---
 rtl/dft_preproc_if.sv | 35 +++
 rtl/dft_preproc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dft_preproc_if.sv
// Sample-stream bundle for the DFT pre-processor: input block stream, flow
// status and the resampled FFT-side output stream.
interface dft_preproc_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                         block_sync_i;
  logic                         data_val_i;
  logic signed [DATA_WIDTH-1:0] data_real_i;
  logic signed [DATA_WIDTH-1:0] data_imag_i;
  logic [11:0]                  trans_len_i;
  logic [3:0]                   ldn_rg_i;
  logic                         in_rdy_o;
  logic                         ovf_o;
  logic                         cfg_err_o;
  logic                         block_sync_o;
  logic                         data_val_o;
  logic signed [DATA_WIDTH-1:0] data_real_o;
  logic signed [DATA_WIDTH-1:0] data_imag_o;
  logic [11:0]                  trans_len_o;
  logic [3:0]                   ldn_o;

  // Source / sink side (testbench or upstream stage).
  modport master (
    output block_sync_i, data_val_i, data_real_i, data_imag_i, trans_len_i, ldn_rg_i,
    input  in_rdy_o, ovf_o, cfg_err_o, block_sync_o, data_val_o, data_real_o, data_imag_o,
           trans_len_o, ldn_o
  );

  // Pre-processor side.
  modport slave (
    input  block_sync_i, data_val_i, data_real_i, data_imag_i, trans_len_i, ldn_rg_i,
    output in_rdy_o, ovf_o, cfg_err_o, block_sync_o, data_val_o, data_real_o, data_imag_o,
           trans_len_o, ldn_o
  );
endinterface

// File: rtl/dft_preproc.sv
// Any-point DFT front end: buffers an N-point block into a ping-pong bank and
// resamples it by circular linear interpolation to M = 2^ldn points.
module dft_preproc #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_N      = 1536,
  parameter int unsigned FRAC_BITS  = 10
) (
  input  logic         clk_sys,
  input  logic         rst_sys_n,
  dft_preproc_if.slave bus
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = $clog2(MAX_N);
  localparam int unsigned PW = DW + FRAC_BITS + 2;
  localparam logic signed [PW-1:0] Half = PW'(1) << (FRAC_BITS - 1);

  typedef enum logic {StIdle, StRun} rd_state_e;

  // Banks hold {real, imag}.
  logic [2*DW-1:0] mem0 [MAX_N];
  logic [2*DW-1:0] mem1 [MAX_N];

  // Write side state.
  logic             wr_bank_q, wr_active_q, ovf_q, cfg_err_q;
  logic [11:0]      wr_addr_q;
  logic [1:0]       full_q;
  logic [1:0][11:0] cfg_n_q;
  logic [1:0][3:0]  cfg_ldn_q;

  // Read side state.
  rd_state_e   rd_state_q;
  logic        rd_bank_q;
  logic [15:0] m_q, r_q;
  logic [11:0] idx_q;

  // Pipeline registers.
  logic                 s1_val_q, s1_sync_q;
  logic [2*DW-1:0]      s1_x0_q, s1_x1_q;
  logic [FRAC_BITS-1:0] s1_w_q;
  logic [11:0]          s1_n_q, trans_len_q;
  logic [3:0]           s1_ldn_q, ldn_q;
  logic                 val_q, sync_q;
  logic signed [DW-1:0] re_q, im_q;

  // Write-side decode.
  logic        in_rdy, cfg_bad, sync_ok, wr_start, wr_cont, wr_en, wr_last;
  logic [15:0] sync_m;
  logic [11:0] wr_n, wr_ptr;

  assign in_rdy   = ~(full_q[0] & full_q[1]);
  assign sync_m   = 16'd1 << bus.ldn_rg_i;
  assign cfg_bad  = ({4'd0, bus.trans_len_i} > sync_m) || (bus.trans_len_i > 12'(MAX_N));
  assign sync_ok  = bus.data_val_i & bus.block_sync_i & in_rdy;
  assign wr_start = sync_ok & ~cfg_bad;
  assign wr_cont  = bus.data_val_i & ~bus.block_sync_i & in_rdy & wr_active_q;
  assign wr_en    = wr_start | wr_cont;
  assign wr_n     = wr_start ? bus.trans_len_i : cfg_n_q[wr_bank_q];
  assign wr_ptr   = wr_start ? 12'd0 : wr_addr_q;
  assign wr_last  = wr_en & (wr_ptr == wr_n - 12'd1);

  // Read-side decode: config of the bank being streamed.
  logic [11:0]          rd_n, idx_nx, addr1;
  logic [3:0]           rd_ldn;
  logic [15:0]          rd_m, r_step;
  logic                 run, rd_free;
  logic [FRAC_BITS-1:0] w_now;

  assign rd_n    = cfg_n_q[rd_bank_q];
  assign rd_ldn  = cfg_ldn_q[rd_bank_q];
  assign rd_m    = 16'd1 << rd_ldn;
  assign run     = (rd_state_q == StRun);
  assign rd_free = run && (m_q == rd_m - 16'd1);
  assign r_step  = r_q + {4'd0, rd_n};
  assign idx_nx  = idx_q + 12'd1;
  assign addr1   = (idx_nx == rd_n) ? 12'd0 : idx_nx;
  // r < M, so the shifted value always fits in FRAC_BITS.
  assign w_now   = FRAC_BITS'({r_q, {FRAC_BITS{1'b0}}} >> rd_ldn);

  // x0 + round_half_away((x1 - x0) * w / 2^FRAC_BITS)
  function automatic logic signed [DW-1:0] interp(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b,
                                                  input logic [FRAC_BITS-1:0] w);
    logic signed [DW:0]   diff;
    logic signed [PW-1:0] prod, rnd;
    logic signed [DW:0]   sum;
    diff = {b[DW-1], b} - {a[DW-1], a};
    prod = PW'(diff) * PW'($signed({1'b0, w}));
    rnd  = prod[PW-1] ? prod + (Half - PW'(1)) : prod + Half;
    sum  = (DW+1)'(rnd >>> FRAC_BITS) + {a[DW-1], a};
    return sum[DW-1:0];
  endfunction

  // Bank storage write; no reset, validity is tracked by full_q.
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      if (wr_bank_q) mem1[wr_ptr[AW-1:0]] <= {bus.data_real_i, bus.data_imag_i};
      else           mem0[wr_ptr[AW-1:0]] <= {bus.data_real_i, bus.data_imag_i};
    end
  end

  // Write control: block framing, bank full flags and error pulses.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      wr_bank_q   <= 1'b0;
      wr_active_q <= 1'b0;
      wr_addr_q   <= '0;
      full_q      <= '0;
      cfg_n_q     <= '0;
      cfg_ldn_q   <= '0;
      ovf_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      ovf_q     <= bus.data_val_i & ~in_rdy;
      cfg_err_q <= sync_ok & cfg_bad;
      if (sync_ok & cfg_bad) wr_active_q <= 1'b0;
      if (wr_start) begin
        cfg_n_q[wr_bank_q]   <= bus.trans_len_i;
        cfg_ldn_q[wr_bank_q] <= bus.ldn_rg_i;
      end
      if (wr_en) begin
        if (wr_last) begin
          wr_active_q <= 1'b0;
          wr_bank_q   <= ~wr_bank_q;
        end else begin
          wr_active_q <= 1'b1;
          wr_addr_q   <= wr_ptr + 12'd1;
        end
      end
      // Freed and filled banks are always different banks.
      if (rd_free) full_q[rd_bank_q] <= 1'b0;
      if (wr_last) full_q[wr_bank_q] <= 1'b1;
    end
  end

  // Read FSM: issues one output index per clock and tracks the phase (idx, r).
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rd_state_q <= StIdle;
      rd_bank_q  <= 1'b0;
      m_q        <= '0;
      idx_q      <= '0;
      r_q        <= '0;
    end else begin
      unique case (rd_state_q)
        StIdle: begin
          m_q   <= '0;
          idx_q <= '0;
          r_q   <= '0;
          if (full_q[rd_bank_q]) rd_state_q <= StRun;
        end
        StRun: begin
          if (rd_free) begin
            rd_bank_q <= ~rd_bank_q;
            m_q       <= '0;
            idx_q     <= '0;
            r_q       <= '0;
            if (!full_q[~rd_bank_q]) rd_state_q <= StIdle;
          end else begin
            m_q <= m_q + 16'd1;
            if (r_step >= rd_m) begin
              r_q   <= r_step - rd_m;
              idx_q <= idx_nx;
            end else begin
              r_q <= r_step;
            end
          end
        end
        default: rd_state_q <= StIdle;
      endcase
    end
  end

  // Stage 1: fetch both neighbours. With N == M the weight is always 0 and
  // idx == m, so bypass falls out of the interpolator exactly.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      s1_val_q  <= 1'b0;
      s1_sync_q <= 1'b0;
      s1_x0_q   <= '0;
      s1_x1_q   <= '0;
      s1_w_q    <= '0;
      s1_n_q    <= '0;
      s1_ldn_q  <= '0;
    end else begin
      s1_val_q  <= run;
      s1_sync_q <= run && (m_q == 16'd0);
      s1_x0_q   <= rd_bank_q ? mem1[idx_q[AW-1:0]] : mem0[idx_q[AW-1:0]];
      s1_x1_q   <= rd_bank_q ? mem1[addr1[AW-1:0]] : mem0[addr1[AW-1:0]];
      s1_w_q    <= w_now;
      s1_n_q    <= rd_n;
      s1_ldn_q  <= rd_ldn;
    end
  end

  // Stage 2: interpolate and register all outputs.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      val_q       <= 1'b0;
      sync_q      <= 1'b0;
      re_q        <= '0;
      im_q        <= '0;
      trans_len_q <= '0;
      ldn_q       <= '0;
    end else begin
      val_q  <= s1_val_q;
      sync_q <= s1_sync_q;
      re_q   <= s1_val_q ? interp(s1_x0_q[2*DW-1:DW], s1_x1_q[2*DW-1:DW], s1_w_q) : '0;
      im_q   <= s1_val_q ? interp(s1_x0_q[DW-1:0], s1_x1_q[DW-1:0], s1_w_q) : '0;
      if (s1_sync_q) begin
        trans_len_q <= s1_n_q;
        ldn_q       <= s1_ldn_q;
      end
    end
  end

  assign bus.in_rdy_o     = in_rdy;
  assign bus.ovf_o        = ovf_q;
  assign bus.cfg_err_o    = cfg_err_q;
  assign bus.block_sync_o = sync_q;
  assign bus.data_val_o   = val_q;
  assign bus.data_real_o  = re_q;
  assign bus.data_imag_o  = im_q;
  assign bus.trans_len_o  = trans_len_q;
  assign bus.ldn_o        = ldn_q;

endmodule
